// File: rtl/traffic_ctrl_multi.sv
// Highway / multi-side-road traffic light controller.
// The highway is the default phase, and side roads are served one at a time in round-robin order.
module traffic_ctrl_multi #(
    parameter int N_SIDE         = 2,
    parameter int CNT_W          = 8,
    parameter int MIN_GREEN_MAIN = 8,
    parameter int MIN_GREEN_SIDE = 2,
    parameter int MAX_GREEN_SIDE = 6,
    parameter int Y2R_DELAY      = 3,
    parameter int R2G_DELAY      = 2,
    localparam int AW            = (N_SIDE > 1) ? $clog2(N_SIDE) : 1
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic [N_SIDE-1:0]     car_req,
    output logic [1:0]            hwy,
    output logic [2*N_SIDE-1:0]   side,
    output logic [AW-1:0]         active_side
);

    localparam int MAX_CNT = (1 << CNT_W) - 1;

    if (N_SIDE < 1 || N_SIDE > 8) begin : g_bad_nside
        $error("traffic_ctrl_multi: N_SIDE must be 1..8");
    end
    if (MIN_GREEN_MAIN < 1 || MIN_GREEN_MAIN > MAX_CNT ||
        MIN_GREEN_SIDE < 1 || MIN_GREEN_SIDE > MAX_CNT ||
        MAX_GREEN_SIDE < 1 || MAX_GREEN_SIDE > MAX_CNT ||
        Y2R_DELAY < 1 || Y2R_DELAY > MAX_CNT ||
        R2G_DELAY < 1 || R2G_DELAY > MAX_CNT ||
        MIN_GREEN_SIDE > MAX_GREEN_SIDE) begin : g_bad_delay
        $error("traffic_ctrl_multi: illegal delay parameters");
    end

    localparam logic [1:0] RED    = 2'd0;
    localparam logic [1:0] YELLOW = 2'd1;
    localparam logic [1:0] GREEN  = 2'd2;

    localparam logic [CNT_W-1:0] T_MIN_MAIN = CNT_W'(MIN_GREEN_MAIN - 1);
    localparam logic [CNT_W-1:0] T_MIN_SIDE = CNT_W'(MIN_GREEN_SIDE - 1);
    localparam logic [CNT_W-1:0] T_MAX_SIDE = CNT_W'(MAX_GREEN_SIDE - 1);
    localparam logic [CNT_W-1:0] T_Y2R      = CNT_W'(Y2R_DELAY - 1);
    localparam logic [CNT_W-1:0] T_R2G      = CNT_W'(R2G_DELAY - 1);

    typedef enum logic [2:0] {
        HWY_G, HWY_Y, AR_TO_SIDE, SIDE_G, SIDE_Y, AR_TO_HWY
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      timer_q, timer_d;
    logic [N_SIDE-1:0]     pend_q, pend_d;
    logic [AW-1:0]         rr_q, rr_d;
    logic [AW-1:0]         sel_q, sel_d;
    logic [1:0]            hwy_q, hwy_d;
    logic [2*N_SIDE-1:0]   side_q, side_d;

    logic [N_SIDE-1:0]     req;
    logic [N_SIDE-1:0]     serve_mask;
    logic [AW-1:0]         pick;
    logic                  found;

    always_comb begin
        req   = pend_q | car_req;
        found = 1'b0;
        pick  = '0;
        // Round-robin search starting at rr_q, first hit wins.
        for (int i = 0; i < N_SIDE; i++) begin
            if (!found && req[(int'(rr_q) + i) % N_SIDE]) begin
                found = 1'b1;
                pick  = AW'((int'(rr_q) + i) % N_SIDE);
            end
        end

        state_d = state_q;
        sel_d   = sel_q;
        rr_d    = rr_q;
        case (state_q)
            HWY_G: begin
                if (timer_q >= T_MIN_MAIN && found) begin
                    state_d = HWY_Y;
                    sel_d   = pick;
                    rr_d    = (pick == AW'(N_SIDE - 1)) ? '0 : pick + AW'(1);
                end
            end
            HWY_Y:      if (timer_q == T_Y2R) state_d = AR_TO_SIDE;
            AR_TO_SIDE: if (timer_q == T_R2G) state_d = SIDE_G;
            SIDE_G: begin
                if (timer_q == T_MAX_SIDE || (!car_req[sel_q] && timer_q >= T_MIN_SIDE))
                    state_d = SIDE_Y;
            end
            SIDE_Y:     if (timer_q == T_Y2R) state_d = AR_TO_HWY;
            AR_TO_HWY: begin
                if (timer_q == T_R2G) begin
                    state_d = HWY_G;
                    sel_d   = '0;
                end
            end
            default:    state_d = HWY_G;
        endcase

        if (state_d != state_q)
            timer_d = '0;
        else
            timer_d = (timer_q == '1) ? timer_q : timer_q + CNT_W'(1);

        // The side currently on green does not re-pend its own sensor.
        serve_mask = (state_q == SIDE_G) ? (N_SIDE'(1) << sel_q) : '0;
        pend_d     = pend_q | (car_req & ~serve_mask);
        if (state_q == AR_TO_SIDE && state_d == SIDE_G)
            pend_d[sel_q] = 1'b0;

        hwy_d  = RED;
        side_d = '0;
        case (state_d)
            HWY_G:   hwy_d = GREEN;
            HWY_Y:   hwy_d = YELLOW;
            SIDE_G:  side_d[int'(sel_d)*2 +: 2] = GREEN;
            SIDE_Y:  side_d[int'(sel_d)*2 +: 2] = YELLOW;
            default: hwy_d = RED;
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= HWY_G;
            timer_q <= '0;
            pend_q  <= '0;
            rr_q    <= '0;
            sel_q   <= '0;
            hwy_q   <= GREEN;
            side_q  <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            pend_q  <= pend_d;
            rr_q    <= rr_d;
            sel_q   <= sel_d;
            hwy_q   <= hwy_d;
            side_q  <= side_d;
        end
    end

    assign hwy         = hwy_q;
    assign side        = side_q;
    assign active_side = sel_q;

endmodule

// File: tb/tb_traffic_ctrl_multi.sv
// Directed bench for traffic_ctrl_multi (default parameters, two side roads).
// Expected per-cycle outputs are queued from the timing rules and popped once per clock.
module tb_traffic_ctrl_multi;

    localparam logic [1:0] R = 2'd0;
    localparam logic [1:0] Y = 2'd1;
    localparam logic [1:0] G = 2'd2;

    logic       clock = 1'b0;
    logic       clear = 1'b1;
    logic [1:0] car_req = 2'b00;
    logic [1:0] hwy;
    logic [3:0] side;
    logic [0:0] active_side;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct packed {
        logic [1:0] h;
        logic [3:0] s;
        logic [0:0] a;
    } exp_t;

    exp_t sb[$];

    traffic_ctrl_multi dut (
        .clock       (clock),
        .clear       (clear),
        .car_req     (car_req),
        .hwy         (hwy),
        .side        (side),
        .active_side (active_side)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic push(input logic [1:0] h, input logic [3:0] s, input logic a, input int n);
        exp_t e;
        e.h = h;
        e.s = s;
        e.a = a;
        repeat (n) sb.push_back(e);
    endtask

    // One side-road service followed by the minimum highway green.
    task automatic push_service(input logic k);
        logic [3:0] sg;
        logic [3:0] sy;
        sg = k ? 4'b1000 : 4'b0010;
        sy = k ? 4'b0100 : 4'b0001;
        push(Y, 4'b0000, k, 3);
        push(R, 4'b0000, k, 2);
        push(R, sg, k, 6);
        push(R, sy, k, 3);
        push(R, 4'b0000, k, 2);
        push(G, 4'b0000, 1'b0, 8);
    endtask

    task automatic check_now();
        exp_t e;
        logic ok;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 8'd1, 8'd0);
        end else begin
            e = sb.pop_front();
            chk("hwy", {6'd0, hwy}, {6'd0, e.h});
            chk("side", {4'd0, side}, {4'd0, e.s});
            chk("active_side", {7'd0, active_side}, {7'd0, e.a});
        end
        ok = (hwy != 2'd3) && (side[1:0] != 2'd3) && (side[3:2] != 2'd3) &&
             !(side[1:0] != 2'd0 && side[3:2] != 2'd0) &&
             !(hwy != 2'd0 && side != 4'd0);
        chk("invariant", {7'd0, ok}, 8'd1);
    endtask

    task automatic run(input int n);
        repeat (n) begin
            check_now();
            @(negedge clock);
            #1;
            cyc++;
        end
    endtask

    // Hold reset for a few edges, check the reset state, release on a falling edge.
    task automatic do_reset();
        clear = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        push(G, 4'b0000, 1'b0, 1);
        check_now();
        @(negedge clock);
        clear = 1'b0;
        #1;
        cyc = 0;
    endtask

    initial begin
        // Idle highway.
        car_req = 2'b00;
        do_reset();
        push(G, 4'b0000, 1'b0, 100);
        run(100);

        // Single held request on side 0 from cycle 2.
        do_reset();
        push(G, 4'b0000, 1'b0, 8);
        push(Y, 4'b0000, 1'b0, 3);
        push(R, 4'b0000, 1'b0, 2);
        push(R, 4'b0010, 1'b0, 6);
        push(R, 4'b0001, 1'b0, 3);
        push(R, 4'b0000, 1'b0, 2);
        push(G, 4'b0000, 1'b0, 1);
        run(2);
        car_req = 2'b01;
        run(23);
        car_req = 2'b00;

        // One-cycle pulse on side 1 at cycle 20.
        do_reset();
        push(G, 4'b0000, 1'b0, 21);
        run(20);
        car_req = 2'b10;
        run(1);
        car_req = 2'b00;
        push(Y, 4'b0000, 1'b1, 3);
        push(R, 4'b0000, 1'b1, 2);
        push(R, 4'b1000, 1'b1, 2);
        push(R, 4'b0100, 1'b1, 3);
        push(R, 4'b0000, 1'b1, 2);
        push(G, 4'b0000, 1'b0, 10);
        run(22);

        // Both sides held: service alternates 0,1,0,1.
        do_reset();
        car_req = 2'b11;
        push(G, 4'b0000, 1'b0, 8);
        push_service(1'b0);
        push_service(1'b1);
        push_service(1'b0);
        push_service(1'b1);
        run(104);
        car_req = 2'b00;

        // Asynchronous clear during side 1 yellow; pending must be dropped.
        do_reset();
        car_req = 2'b10;
        push(G, 4'b0000, 1'b0, 8);
        push(Y, 4'b0000, 1'b1, 3);
        push(R, 4'b0000, 1'b1, 2);
        push(R, 4'b1000, 1'b1, 6);
        push(R, 4'b0100, 1'b1, 2);
        run(21);
        #2;
        clear = 1'b1;
        #1;
        push(G, 4'b0000, 1'b0, 1);
        check_now();
        car_req = 2'b00;
        repeat (2) @(posedge clock);
        @(negedge clock);
        clear = 1'b0;
        #1;
        cyc = 0;
        push(G, 4'b0000, 1'b0, 30);
        run(30);

        chk("scoreboard_drained", 8'(sb.size()), 8'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
